// File: rtl/rounding_pipe.sv
// Two-stage IEEE-754 rounding stage with post-rounding renormalization and valid/ready on both sides.
// Define ROUND_FLAGS_EN to add the out_flags = {overflow, inexact} port and its pipeline registers.
module rounding_pipe #(
    parameter int FRAC_W  = 23,
    parameter int EXP_W   = 10,
    parameter int REM_W   = 27,
    parameter int EXP_MAX = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sign,
    input  logic [2:0]          in_rmode,
    input  logic                in_sticky_sel,
    input  logic [EXP_W-1:0]    in_exponent,
    input  logic [2*FRAC_W+2:0] in_fraction,
    input  logic [REM_W-1:0]    in_remainder,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [EXP_W-1:0]    out_exponent,
    output logic [FRAC_W+1:0]   out_fraction
`ifdef ROUND_FLAGS_EN
    ,
    output logic [1:0]          out_flags
`endif
);

    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    logic                r_s1_valid;
    logic                r_s2_valid;
    logic [FRAC_W:0]     r_s1_keep;
    logic [EXP_W-1:0]    r_s1_exp;
    logic                r_s1_incr;
    logic [EXP_W-1:0]    r_s2_exp;
    logic [FRAC_W+1:0]   r_s2_frac;

    logic                w_s1_adv;
    logic                w_s2_adv;
    logic                w_lsb;
    logic                w_guard;
    logic                w_round;
    logic                w_sticky;
    logic                w_inexact;
    logic                w_incr;
    logic [FRAC_W+1:0]   w_rf;
    logic                w_carry;
    logic [FRAC_W+1:0]   w_s2_frac;
    logic [EXP_W-1:0]    w_s2_exp;

    // A stage takes new data when it is empty or its content moves on this edge;
    // a beat transfers on any edge where valid & ready are both high.
    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    assign w_lsb     = in_fraction[FRAC_W+1];
    assign w_guard   = in_fraction[FRAC_W];
    assign w_round   = in_fraction[FRAC_W-1];
    assign w_sticky  = in_sticky_sel ? (|in_remainder) : (|in_fraction[FRAC_W-2:0]);
    assign w_inexact = w_guard || w_round || w_sticky;

    // Unlisted rounding modes (5-7) fall through to round-to-nearest-even.
    always_comb begin
        w_incr = 1'b0;
        case (in_rmode)
            RM_RTZ:  w_incr = 1'b0;
            RM_RDN:  w_incr = in_sign && w_inexact;
            RM_RUP:  w_incr = !in_sign && w_inexact;
            RM_RMM:  w_incr = w_guard;
            default: w_incr = w_guard && (w_round || w_sticky || w_lsb);
        endcase
    end

    // A carry out of the kept field means the mantissa rolled over to 10.000...
    assign w_rf      = {1'b0, r_s1_keep} + {{(FRAC_W+1){1'b0}}, r_s1_incr};
    assign w_carry   = w_rf[FRAC_W+1];
    assign w_s2_frac = w_carry ? (w_rf >> 1) : w_rf;
    assign w_s2_exp  = r_s1_exp + {{(EXP_W-1){1'b0}}, w_carry};

`ifdef ROUND_FLAGS_EN
    logic       r_s1_inexact;
    logic [1:0] r_s2_flags;
    logic       w_ovf;

    assign w_ovf     = (w_s2_exp >= EXP_W'(EXP_MAX));
    assign out_flags = r_s2_flags;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_inexact <= 1'b0;
            r_s2_flags   <= 2'b00;
        end else begin
            if (w_s1_adv && in_valid && !flush)
                r_s1_inexact <= w_inexact;
            if (w_s2_adv && r_s1_valid && !flush)
                r_s2_flags <= {w_ovf, r_s1_inexact};
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s1_keep  <= '0;
            r_s1_exp   <= '0;
            r_s1_incr  <= 1'b0;
            r_s2_exp   <= '0;
            r_s2_frac  <= '0;
        end else begin
            if (flush) begin
                r_s1_valid <= 1'b0;
                r_s2_valid <= 1'b0;
            end else begin
                if (w_s1_adv)
                    r_s1_valid <= in_valid;
                if (w_s2_adv)
                    r_s2_valid <= r_s1_valid;
            end
            // Data registers only move with a real beat, so out_* holds while empty.
            if (w_s1_adv && in_valid && !flush) begin
                r_s1_keep <= in_fraction[2*FRAC_W+1:FRAC_W+1];
                r_s1_exp  <= in_exponent;
                r_s1_incr <= w_incr;
            end
            if (w_s2_adv && r_s1_valid && !flush) begin
                r_s2_exp  <= w_s2_exp;
                r_s2_frac <= w_s2_frac;
            end
        end
    end

    assign out_valid    = r_s2_valid;
    assign out_exponent = r_s2_exp;
    assign out_fraction = r_s2_frac;

endmodule

// File: tb/tb_rounding_pipe.sv
// Directed bench for rounding_pipe: vector table, backpressure stream, reset and flush sequences.
// Flag checks are compiled in when ROUND_FLAGS_EN is defined.
module tb_rounding_pipe;

    localparam int FRAC_W = 23;
    localparam int EXP_W  = 10;
    localparam int REM_W  = 27;
    localparam int NVEC   = 17;

    logic                clk;
    logic                reset_n;
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic                in_sign;
    logic [2:0]          in_rmode;
    logic                in_sticky_sel;
    logic [EXP_W-1:0]    in_exponent;
    logic [2*FRAC_W+2:0] in_fraction;
    logic [REM_W-1:0]    in_remainder;
    logic                out_valid;
    logic                out_ready;
    logic [EXP_W-1:0]    out_exponent;
    logic [FRAC_W+1:0]   out_fraction;
`ifdef ROUND_FLAGS_EN
    logic [1:0]          out_flags;
`endif

    rounding_pipe #(.FRAC_W(FRAC_W), .EXP_W(EXP_W), .REM_W(REM_W), .EXP_MAX(255)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_rmode      (in_rmode),
        .in_sticky_sel (in_sticky_sel),
        .in_exponent   (in_exponent),
        .in_fraction   (in_fraction),
        .in_remainder  (in_remainder),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_exponent  (out_exponent),
        .out_fraction  (out_fraction)
`ifdef ROUND_FLAGS_EN
        ,
        .out_flags     (out_flags)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [34:0] exp_q[$];

    typedef struct packed {
        logic [2:0]  rm;
        logic        sg;
        logic        sel;
        logic [9:0]  ex;
        logic [23:0] keep;
        logic        g;
        logic        r;
        logic [21:0] low;
        logic [26:0] rem;
        logic [9:0]  x_exp;
        logic [24:0] x_frac;
        logic [1:0]  x_flags;
    } vec_t;

    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic set_beat(input logic [2:0] rm, input logic sg, input logic sel,
                            input logic [9:0] ex, input logic [23:0] keep, input logic g,
                            input logic r, input logic [21:0] low, input logic [26:0] rem);
        in_rmode      = rm;
        in_sign       = sg;
        in_sticky_sel = sel;
        in_exponent   = ex;
        in_fraction   = {1'b0, keep, g, r, low};
        in_remainder  = rem;
    endtask

    // Two beats accepted back-to-back with out_ready low leave both stages full.
    task automatic fill_two();
        out_ready = 1'b0;
        @(posedge clk); #1;
        set_beat(3'd0, 1'b0, 1'b0, 10'd40, 24'h900000, 1'b0, 1'b0, 22'h0, 27'h0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        set_beat(3'd0, 1'b0, 1'b0, 10'd41, 24'hA00000, 1'b0, 1'b0, 22'h0, 27'h0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("full_out_valid", 64'(out_valid), 64'd1);
        check("full_in_ready", 64'(in_ready), 64'd0);
    endtask

    bit pat[4];

    initial begin
        vecs[0]  = '{3'd0, 1'b0, 1'b0, 10'd127, 24'h800000, 1'b1, 1'b0, 22'h0, 27'h0, 10'd127, 25'h0800000, 2'b01};
        vecs[1]  = '{3'd0, 1'b0, 1'b0, 10'd127, 24'h800001, 1'b1, 1'b0, 22'h0, 27'h0, 10'd127, 25'h0800002, 2'b01};
        vecs[2]  = '{3'd0, 1'b0, 1'b0, 10'd254, 24'hFFFFFF, 1'b1, 1'b0, 22'h0, 27'h0, 10'd255, 25'h0800000, 2'b11};
        vecs[3]  = '{3'd3, 1'b0, 1'b0, 10'd100, 24'h800000, 1'b0, 1'b0, 22'h1, 27'h0, 10'd100, 25'h0800001, 2'b01};
        vecs[4]  = '{3'd3, 1'b1, 1'b0, 10'd100, 24'h800000, 1'b0, 1'b0, 22'h1, 27'h0, 10'd100, 25'h0800000, 2'b01};
        vecs[5]  = '{3'd2, 1'b1, 1'b0, 10'd100, 24'h800000, 1'b0, 1'b0, 22'h1, 27'h0, 10'd100, 25'h0800001, 2'b01};
        vecs[6]  = '{3'd1, 1'b0, 1'b0, 10'd100, 24'h800000, 1'b0, 1'b0, 22'h1, 27'h0, 10'd100, 25'h0800000, 2'b01};
        vecs[7]  = '{3'd4, 1'b0, 1'b0, 10'd100, 24'h800000, 1'b0, 1'b0, 22'h1, 27'h0, 10'd100, 25'h0800000, 2'b01};
        vecs[8]  = '{3'd0, 1'b0, 1'b1, 10'd100, 24'h800000, 1'b1, 1'b0, 22'h0, 27'h1, 10'd100, 25'h0800001, 2'b01};
        vecs[9]  = '{3'd0, 1'b0, 1'b0, 10'd100, 24'h800000, 1'b1, 1'b0, 22'h0, 27'h1, 10'd100, 25'h0800000, 2'b01};
        vecs[10] = '{3'd0, 1'b0, 1'b0, 10'd5,   24'hABCDEF, 1'b0, 1'b0, 22'h0, 27'h0, 10'd5,   25'h0ABCDEF, 2'b00};
        vecs[11] = '{3'd4, 1'b0, 1'b0, 10'd100, 24'h800000, 1'b1, 1'b0, 22'h0, 27'h0, 10'd100, 25'h0800001, 2'b01};
        vecs[12] = '{3'd6, 1'b0, 1'b0, 10'd100, 24'h800001, 1'b1, 1'b0, 22'h0, 27'h0, 10'd100, 25'h0800002, 2'b01};
        vecs[13] = '{3'd2, 1'b0, 1'b0, 10'd100, 24'h800000, 1'b1, 1'b1, 22'h0, 27'h0, 10'd100, 25'h0800000, 2'b01};
        vecs[14] = '{3'd0, 1'b0, 1'b0, 10'd254, 24'h800000, 1'b1, 1'b1, 22'h0, 27'h0, 10'd254, 25'h0800001, 2'b01};
        vecs[15] = '{3'd0, 1'b0, 1'b0, 10'd255, 24'h800000, 1'b0, 1'b0, 22'h0, 27'h0, 10'd255, 25'h0800000, 2'b10};
        vecs[16] = '{3'd0, 1'b0, 1'b1, 10'd100, 24'h800000, 1'b1, 1'b0, 22'h1, 27'h0, 10'd100, 25'h0800000, 2'b01};
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_beat(3'd0, 1'b0, 1'b0, 10'd0, 24'h0, 1'b0, 1'b0, 22'h0, 27'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_exp", 64'(out_exponent), 64'd0);
        check("rst_out_frac", 64'(out_fraction), 64'd0);
`ifdef ROUND_FLAGS_EN
        check("rst_out_flags", 64'(out_flags), 64'd0);
`endif
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Vector table: one beat at a time, two-edge latency
        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk); #1;
            set_beat(vecs[i].rm, vecs[i].sg, vecs[i].sel, vecs[i].ex, vecs[i].keep,
                     vecs[i].g, vecs[i].r, vecs[i].low, vecs[i].rem);
            in_valid = 1'b1;
            @(negedge clk);
            check($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'd1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            check($sformatf("v%0d_early_valid", i), 64'(out_valid), 64'd0);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("v%0d_frac", i), 64'(out_fraction), 64'(vecs[i].x_frac));
            check($sformatf("v%0d_exp", i), 64'(out_exponent), 64'(vecs[i].x_exp));
`ifdef ROUND_FLAGS_EN
            check($sformatf("v%0d_flags", i), 64'(out_flags), 64'(vecs[i].x_flags));
`endif
        end
        @(posedge clk); #1;

        // Backpressure stream with out_ready cycling 1,0,0,1
        begin
            int cyc;
            int got;
            bit prev_stall;
            logic [34:0] prev_data;
            cyc = 0;
            got = 0;
            prev_stall = 1'b0;
            prev_data = '0;
            out_ready = pat[0];
            fork
                begin
                    for (int i = 0; i < 8; i++) begin
                        logic [23:0] k;
                        logic [9:0]  e;
                        bit acc;
                        int t;
                        k = 24'h800000 + 24'(i * 3);
                        e = 10'(20 + i);
                        set_beat(3'd1, 1'b0, 1'b0, e, k, 1'b1, 1'b0, 22'h0, 27'h0);
                        exp_q.push_back({e, 1'b0, k});
                        in_valid = 1'b1;
                        acc = 1'b0;
                        t = 0;
                        while (!acc && t < 50) begin
                            @(negedge clk);
                            acc = in_ready;
                            @(posedge clk); #1;
                            t++;
                        end
                        if (!acc) check("bp_drv_timeout", 64'd0, 64'd1);
                    end
                    in_valid = 1'b0;
                end
                begin
                    while (got < 8 && cyc < 200) begin
                        @(negedge clk);
                        if (prev_stall) begin
                            check("bp_hold_valid", 64'(out_valid), 64'd1);
                            check("bp_hold_data", 64'({out_exponent, out_fraction}), 64'(prev_data));
                        end
                        if (out_ready) check("bp_ready_drain", 64'(in_ready), 64'd1);
                        if (!out_valid) check("bp_ready_empty", 64'(in_ready), 64'd1);
                        if (out_valid && out_ready) begin
                            if (exp_q.size() == 0) begin
                                check("bp_extra_beat", 64'd1, 64'd0);
                            end else begin
                                check($sformatf("bp_beat%0d", got), 64'({out_exponent, out_fraction}),
                                      64'(exp_q.pop_front()));
                            end
                            got++;
                        end
                        prev_stall = out_valid && !out_ready;
                        prev_data  = {out_exponent, out_fraction};
                        @(posedge clk); #1;
                        cyc++;
                        out_ready = pat[cyc % 4];
                    end
                end
            join
            check("bp_count", 64'(got), 64'd8);
            check("bp_queue_empty", 64'(exp_q.size()), 64'd0);
            out_ready = 1'b1;
            repeat (4) begin
                @(negedge clk);
                check("bp_no_extra", 64'(out_valid), 64'd0);
            end
        end

        // Async reset with two beats in flight
        @(posedge clk); #1;
        fill_two();
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_out_exp", 64'(out_exponent), 64'd0);
        check("arst_out_frac", 64'(out_fraction), 64'd0);
`ifdef ROUND_FLAGS_EN
        check("arst_out_flags", 64'(out_flags), 64'd0);
`endif
        @(posedge clk); #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("arst_in_ready", 64'(in_ready), 64'd1);
            check("arst_no_beat", 64'(out_valid), 64'd0);
        end

        // Flush with two beats in flight; the beat offered alongside flush is dropped
        @(posedge clk); #1;
        fill_two();
        @(posedge clk); #1;
        flush = 1'b1;
        set_beat(3'd0, 1'b0, 1'b0, 10'd50, 24'hB00000, 1'b0, 1'b0, 22'h0, 27'h0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("flush_no_beat", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;
        set_beat(3'd0, 1'b0, 1'b0, 10'd60, 24'hC00001, 1'b1, 1'b0, 22'h0, 27'h0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_next_early", 64'(out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("flush_next_valid", 64'(out_valid), 64'd1);
        check("flush_next_frac", 64'(out_fraction), 64'h0C00002);
        check("flush_next_exp", 64'(out_exponent), 64'd60);
        @(posedge clk);
        @(negedge clk);
        check("flush_next_once", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
